weight_loader: RTL and testbench

- DMA-style writer that fills the double-buffered weight banks through their weight-loading port: `weight_write_en`, `weight_write_bank`, `weight_write_addr` and `weight_write_data`.
- Fetches a contiguous run of weights from global data memory over the valid/ready read interface. Writes them either linearly into one bank or striped across banks.
- On completion, optionally pulses `swap_buffers` so the freshly loaded (inactive) buffer becomes active.
- Sits between the memory controller and the weight/activation memory; launched by the scheduler.

---
 rtl/weight_loader.sv | 135 +++++++++++++
 tb/tb_weight_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: DMA writer that streams words from global memory
// into the double-buffered weight banks, linear or bank-striped.
module weight_loader #(
    parameter int DATA_BITS     = 16,
    parameter int MEM_ADDR_BITS = 8,
    parameter int NUM_BANKS     = 4,
    parameter int BANK_DEPTH    = 1024,
    parameter int LEN_BITS      = $clog2(NUM_BANKS*BANK_DEPTH)+1,
    localparam int BB = $clog2(NUM_BANKS),
    localparam int AB = $clog2(BANK_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MEM_ADDR_BITS-1:0] src_addr,
    input  logic [BB-1:0]            dst_bank,
    input  logic [AB-1:0]            dst_addr,
    input  logic [LEN_BITS-1:0]      length,
    input  logic                     interleave,
    input  logic                     swap_on_done,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_read_valid,
    output logic [MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,
    output logic                     weight_write_en,
    output logic [BB-1:0]            weight_write_bank,
    output logic [AB-1:0]            weight_write_addr,
    output logic [DATA_BITS-1:0]     weight_write_data,
    output logic                     swap_buffers
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WRITE,
        SWAP,
        DONE
    } state_t;

    state_t state, state_n;

    logic [LEN_BITS-1:0] cnt;
    logic [LEN_BITS-1:0] cnt_inc;
    logic [LEN_BITS-1:0] len_q;
    logic                il_q;
    logic                swap_q;
    logic [BB-1:0]       bank_ptr;
    logic [AB-1:0]       addr_ptr;

    assign cnt_inc = cnt + LEN_BITS'(1);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (length == '0) ? DONE : REQUEST;
            end
            REQUEST: begin
                if (mem_read_ready)
                    state_n = WRITE;
            end
            WRITE: begin
                if (cnt_inc == len_q)
                    state_n = swap_q ? SWAP : DONE;
                else
                    state_n = REQUEST;
            end
            SWAP:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            swap_buffers      <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            weight_write_en   <= 1'b0;
            weight_write_bank <= '0;
            weight_write_addr <= '0;
            weight_write_data <= '0;
            cnt               <= '0;
            len_q             <= '0;
            il_q              <= 1'b0;
            swap_q            <= 1'b0;
            bank_ptr          <= '0;
            addr_ptr          <= '0;
        end else begin
            state           <= state_n;
            busy            <= (state_n != IDLE);
            done            <= (state_n == DONE);
            swap_buffers    <= (state_n == SWAP);
            mem_read_valid  <= (state_n == REQUEST);
            weight_write_en <= (state_n == WRITE);

            if (state == IDLE && start) begin
                len_q            <= length;
                il_q             <= interleave;
                swap_q           <= swap_on_done;
                cnt              <= '0;
                mem_read_address <= src_addr;
                bank_ptr         <= dst_bank;
                addr_ptr         <= dst_addr;
            end

            if (state == REQUEST && mem_read_ready) begin
                weight_write_data <= mem_read_data;
                weight_write_bank <= bank_ptr;
                weight_write_addr <= addr_ptr;
            end

            if (state == WRITE) begin
                cnt              <= cnt_inc;
                mem_read_address <= mem_read_address + MEM_ADDR_BITS'(1);
                // Striped mode moves to the next row once per full bank sweep.
                if (il_q) begin
                    bank_ptr <= bank_ptr + BB'(1);
                    if (cnt[BB-1:0] == BB'(NUM_BANKS-1))
                        addr_ptr <= addr_ptr + AB'(1);
                end else begin
                    addr_ptr <= addr_ptr + AB'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed vector table plus hand-written sequences
// for backpressure, reset, start-while-busy and full-length loads.
module tb_weight_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  src_addr;
    logic [1:0]  dst_bank;
    logic [9:0]  dst_addr;
    logic [12:0] length;
    logic        interleave;
    logic        swap_on_done;
    logic        busy;
    logic        done;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        weight_write_en;
    logic [1:0]  weight_write_bank;
    logic [9:0]  weight_write_addr;
    logic [15:0] weight_write_data;
    logic        swap_buffers;

    weight_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_addr          (src_addr),
        .dst_bank          (dst_bank),
        .dst_addr          (dst_addr),
        .length            (length),
        .interleave        (interleave),
        .swap_on_done      (swap_on_done),
        .busy              (busy),
        .done              (done),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .weight_write_en   (weight_write_en),
        .weight_write_bank (weight_write_bank),
        .weight_write_addr (weight_write_addr),
        .weight_write_data (weight_write_data),
        .swap_buffers      (swap_buffers)
    );

    typedef struct packed {
        logic [7:0]       src;
        logic [1:0]       bank;
        logic [9:0]       addr;
        logic [12:0]      len;
        logic             il;
        logic             sw;
        logic [3:0]       st_w;
        logic [3:0]       st_n;
        logic [0:5][7:0]  rd;
        logic [0:5][1:0]  bk;
        logic [0:5][9:0]  ad;
    } vec_t;

    vec_t vt [7];
    vec_t vx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int epoch = 0;
    int start_cyc = 0;
    int st_w = 0;
    int st_n = 0;

    logic [7:0]  rd_q [$];
    logic [1:0]  wb_q [$];
    logic [9:0]  wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];
    int done_cnt, swap_cnt, done_cyc, swap_cyc;
    int stab_n, stab_bad;
    bit seen [0:4095];

    // Memory returns a tagged word only in the accepting cycle.
    assign mem_read_data = mem_read_ready ? {8'hD0, mem_read_address}
                                          : {8'hEE, cyc[7:0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and ready driver, sampling away from the active edge.
    initial begin : monitor
        int seen_epoch;
        bit prev_stall;
        logic [7:0] prev_addr;
        seen_epoch = 0;
        prev_stall = 0;
        prev_addr = '0;
        done_cnt = 0; swap_cnt = 0; done_cyc = 0; swap_cyc = 0;
        stab_n = 0; stab_bad = 0;
        mem_read_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                rd_q.delete(); wb_q.delete(); wa_q.delete();
                wd_q.delete(); wc_q.delete();
                done_cnt = 0; swap_cnt = 0;
                stab_n = 0; stab_bad = 0; prev_stall = 0;
            end
            if (prev_stall && !reset) begin
                stab_n = stab_n + 1;
                if (!mem_read_valid || mem_read_address != prev_addr
                    || weight_write_en)
                    stab_bad = stab_bad + 1;
            end
            if (mem_read_valid && rd_q.size() == st_w
                && (stab_n + (prev_stall ? 0 : 0)) < st_n
                && !reset)
                mem_read_ready = 1'b0;
            else
                mem_read_ready = 1'b1;
            if (mem_read_valid && mem_read_ready)
                rd_q.push_back(mem_read_address);
            if (weight_write_en) begin
                wb_q.push_back(weight_write_bank);
                wa_q.push_back(weight_write_addr);
                wd_q.push_back(weight_write_data);
                wc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (swap_buffers) begin
                swap_cnt = swap_cnt + 1;
                swap_cyc = cyc;
            end
            prev_stall = mem_read_valid && !mem_read_ready && !reset;
            prev_addr = mem_read_address;
        end
    end

    task automatic launch(input vec_t v);
        @(negedge clk);
        src_addr = v.src;
        dst_bank = v.bank;
        dst_addr = v.addr;
        length = v.len;
        interleave = v.il;
        swap_on_done = v.sw;
        st_w = int'(v.st_w);
        st_n = int'(v.st_n);
        epoch = epoch + 1;
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (done_cnt != 0) begin
                got = 1;
                break;
            end
        end
        check("done_timeout", got, 1);
    endtask

    task automatic check_xfer(input vec_t v);
        int n;
        int prev;
        int gap;
        n = int'(v.len);
        check("n_writes", wb_q.size(), n);
        check("n_reads", rd_q.size(), n);
        check("n_done", done_cnt, 1);
        check("n_swap", swap_cnt, (v.sw && n != 0) ? 1 : 0);
        check("stall_cycles", stab_n, v.st_n);
        check("stall_stable", stab_bad, 0);
        if (n == 0) begin
            check("done_latency", done_cyc - start_cyc, 1);
        end else if (wb_q.size() == n && rd_q.size() == n) begin
            for (int k = 0; k < n && k < 6; k++) begin
                prev = (k == 0) ? start_cyc : wc_q[k-1];
                gap = 2 + ((k == int'(v.st_w)) ? int'(v.st_n) : 0);
                check("rd_addr", rd_q[k], v.rd[k]);
                check("wr_bank", wb_q[k], v.bk[k]);
                check("wr_addr", wa_q[k], v.ad[k]);
                check("wr_data", wd_q[k], {8'hD0, v.rd[k]});
                check("wr_spacing", wc_q[k] - prev, gap);
            end
            if (v.sw)
                check("swap_cycle", swap_cyc - wc_q[n-1], 1);
            check("done_cycle", done_cyc - wc_q[n-1], v.sw ? 2 : 1);
        end
    endtask

    initial begin
        int dup;
        int hit;
        int idx;
        reset = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_bank = '0;
        dst_addr = '0;
        length = '0;
        interleave = 1'b0;
        swap_on_done = 1'b0;

        vt[0] = '{8'h10, 2'd2, 10'd5, 13'd3, 1'b0, 1'b0, 4'd0, 4'd0,
                  {8'h10, 8'h11, 8'h12, 24'h0},
                  {2'd2, 2'd2, 2'd2, 6'd0},
                  {10'd5, 10'd6, 10'd7, 30'd0}};
        vt[1] = '{8'h20, 2'd3, 10'd0, 13'd6, 1'b1, 1'b0, 4'd0, 4'd0,
                  {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25},
                  {2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0},
                  {10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd1}};
        vt[2] = '{8'h30, 2'd1, 10'd100, 13'd3, 1'b0, 1'b0, 4'd1, 4'd4,
                  {8'h30, 8'h31, 8'h32, 24'h0},
                  {2'd1, 2'd1, 2'd1, 6'd0},
                  {10'd100, 10'd101, 10'd102, 30'd0}};
        vt[3] = '{8'h40, 2'd0, 10'd7, 13'd2, 1'b0, 1'b1, 4'd0, 4'd0,
                  {8'h40, 8'h41, 32'h0},
                  {2'd0, 2'd0, 8'd0},
                  {10'd7, 10'd8, 40'd0}};
        vt[4] = '{8'h50, 2'd1, 10'd3, 13'd0, 1'b0, 1'b1, 4'd0, 4'd0,
                  48'h0, 12'h0, 60'h0};
        vt[5] = '{8'hFF, 2'd1, 10'd1023, 13'd2, 1'b0, 1'b0, 4'd0, 4'd0,
                  {8'hFF, 8'h00, 32'h0},
                  {2'd1, 2'd1, 8'd0},
                  {10'd1023, 10'd0, 40'd0}};
        vt[6] = '{8'h60, 2'd2, 10'd1023, 13'd5, 1'b1, 1'b1, 4'd0, 4'd0,
                  {8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0},
                  {2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0},
                  {10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd0, 10'd0}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs",
              {busy, done, mem_read_valid, mem_read_address,
               weight_write_en, weight_write_bank, weight_write_addr,
               weight_write_data, swap_buffers}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            launch(vt[i]);
            wait_done(100);
            check_xfer(vt[i]);
        end

        // A second start mid-transfer must be ignored.
        launch(vt[0]);
        repeat (2) @(negedge clk);
        start = 1'b1;
        src_addr = 8'hAA;
        dst_bank = 2'd0;
        dst_addr = 10'd0;
        length = 13'd1;
        interleave = 1'b1;
        swap_on_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        check_xfer(vt[0]);
        repeat (4) @(negedge clk);
        check("idle_after_poke", busy, 0);

        // Reset while a request is stalled.
        vx = vt[0];
        vx.st_w = 4'd0;
        vx.st_n = 4'd15;
        launch(vx);
        repeat (2) @(negedge clk);
        check("pre_reset_valid", mem_read_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs",
              {busy, done, mem_read_valid, mem_read_address,
               weight_write_en, weight_write_bank, weight_write_addr,
               weight_write_data, swap_buffers}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_done", done_cnt, 0);
        check("rst_no_write", wb_q.size(), 0);
        check("rst_no_swap", swap_cnt, 0);
        check("rst_busy", busy, 0);

        launch(vt[1]);
        wait_done(100);
        check_xfer(vt[1]);

        // Full-size striped load must hit every entry exactly once.
        vx = '0;
        vx.len = 13'd4096;
        vx.il = 1'b1;
        launch(vx);
        wait_done(9000);
        check("max_n_writes", wb_q.size(), 4096);
        check("max_n_done", done_cnt, 1);
        check("max_n_swap", swap_cnt, 0);
        for (int k = 0; k < 4096; k++)
            seen[k] = 1'b0;
        dup = 0;
        hit = 0;
        for (int k = 0; k < wb_q.size(); k++) begin
            idx = int'({wb_q[k], wa_q[k]});
            if (seen[idx])
                dup = dup + 1;
            else
                hit = hit + 1;
            seen[idx] = 1'b1;
        end
        check("max_dups", dup, 0);
        check("max_coverage", hit, 4096);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
